// File: rtl/mux_arb_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_reg
// Purpose  : Registered N-channel arbitrating multiplexer. One channel owns
//            the shared data path from grant until its end-of-burst word.
//            Fixed-priority or round-robin winner selection.
// Revision : 1.0 - initial release
// ============================================================================
module mux_arb_reg #(
    parameter int WIDTH   = 16,
    parameter int N_CH    = 4,
    // Derived owner-index width; leave at its default.
    parameter int SEL_W   = $clog2(N_CH),
    parameter int RR_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       req,
    input  logic [N_CH-1:0]       last,
    input  logic [N_CH*WIDTH-1:0] data_in,
    output logic [N_CH-1:0]       grant,
    output logic [WIDTH-1:0]      data_out,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [N_CH-1:0]    grant_q,     grant_d;
    logic [SEL_W-1:0]   owner_q,     owner_d;
    logic [WIDTH-1:0]   data_out_q,  data_out_d;
    logic               out_valid_q, out_valid_d;
    logic [SEL_W-1:0]   out_sel_q,   out_sel_d;
    logic [SEL_W-1:0]   rr_ptr_q,    rr_ptr_d;

    logic [SEL_W-1:0]   win_fp;
    logic [SEL_W-1:0]   win_rr;
    logic [SEL_W-1:0]   win;
    int                 rr_idx;

    // Per-channel view of the flattened data bus.
    logic [WIDTH-1:0]   ch_data [N_CH];

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign ch_data[gi] = data_in[gi*WIDTH +: WIDTH];
    end

    // Winner candidates: lowest set request, and first set request from rr_ptr.
    always_comb begin
        win_fp = '0;
        win_rr = '0;
        rr_idx = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[SEL_W'(i)]) begin
                win_fp = SEL_W'(i);
            end
        end
        // Scanning downward leaves the nearest-to-pointer requester last.
        for (int k = N_CH - 1; k >= 0; k--) begin
            rr_idx = int'(rr_ptr_q) + k;
            if (rr_idx >= N_CH) begin
                rr_idx = rr_idx - N_CH;
            end
            if (req[SEL_W'(rr_idx)]) begin
                win_rr = SEL_W'(rr_idx);
            end
        end
    end

    assign win = (RR_MODE != 0) ? win_rr : win_fp;

    // Next-state and registered-output logic for the IDLE/OWN controller.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;

        case (state_q)
            IDLE: begin
                // Arbitration cycle: nothing transfers here.
                if (|req) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    owner_d      = win;
                    state_d      = OWN;
                    if (RR_MODE != 0) begin
                        rr_ptr_d = (win == SEL_W'(N_CH - 1)) ? '0 : win + SEL_W'(1);
                    end
                end
            end
            OWN: begin
                out_sel_d = owner_q;
                if (req[owner_q]) begin
                    data_out_d  = ch_data[owner_q];
                    out_valid_d = 1'b1;
                    // The last word still transfers; ownership ends with it.
                    if (last[owner_q]) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops ownership and any word in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign grant     = grant_q;
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign busy      = (state_q == OWN);

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_arb_reg
// Purpose  : Directed self-checking bench for mux_arb_reg. A fixed-priority
//            and a round-robin instance share all inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arb_reg;

    localparam int WIDTH = 16;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    logic                  clk;
    logic                  rst_n;
    logic [N_CH-1:0]       req;
    logic [N_CH-1:0]       last;
    logic [N_CH*WIDTH-1:0] data_in;

    logic [N_CH-1:0]  fp_grant,    rr_grant;
    logic [WIDTH-1:0] fp_data_out, rr_data_out;
    logic             fp_valid,    rr_valid;
    logic [SEL_W-1:0] fp_sel,      rr_sel;
    logic             fp_busy,     rr_busy;

    int passed;
    int total;

    mux_arb_reg #(.WIDTH(WIDTH), .N_CH(N_CH), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .data_in(data_in),
        .grant(fp_grant), .data_out(fp_data_out), .out_valid(fp_valid),
        .out_sel(fp_sel), .busy(fp_busy)
    );

    mux_arb_reg #(.WIDTH(WIDTH), .N_CH(N_CH), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .data_in(data_in),
        .grant(rr_grant), .data_out(rr_data_out), .out_valid(rr_valid),
        .out_sel(rr_sel), .busy(rr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [WIDTH-1:0] val);
        data_in[ch*WIDTH +: WIDTH] = val;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = 4'hF;
        last    = 4'h0;
        data_in = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({fp_grant, fp_valid, fp_data_out, fp_busy} !== 22'd0) begin
                $display("FAIL reset_fp cyc%0d: grant=%b valid=%b data=%h busy=%b required all zero",
                         c, fp_grant, fp_valid, fp_data_out, fp_busy);
            end else passed++;
            total++;
            if ({rr_grant, rr_valid, rr_data_out, rr_busy, rr_sel} !== 24'd0) begin
                $display("FAIL reset_rr cyc%0d: grant=%b valid=%b data=%h busy=%b sel=%0d required all zero",
                         c, rr_grant, rr_valid, rr_data_out, rr_busy, rr_sel);
            end else passed++;
        end
        req   = 4'h0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed_priority();
        set_data(1, 16'h1234);
        set_data(3, 16'hDEAD);
        req  = 4'b1010;
        tick();
        total++;
        if (fp_grant !== 4'b0010 || fp_busy !== 1'b1 || fp_valid !== 1'b0) begin
            $display("FAIL fp_grant: grant=%b busy=%b valid=%b required 0010 1 0", fp_grant, fp_busy, fp_valid);
        end else passed++;
        last = 4'b0010;
        tick();
        total++;
        if (fp_data_out !== 16'h1234 || fp_sel !== 2'd1 || fp_valid !== 1'b1) begin
            $display("FAIL fp_word: data=%h sel=%0d valid=%b required 1234 1 1", fp_data_out, fp_sel, fp_valid);
        end else passed++;
        total++;
        if (fp_grant !== 4'b0000 || fp_busy !== 1'b0) begin
            $display("FAIL fp_release: grant=%b busy=%b required 0000 0", fp_grant, fp_busy);
        end else passed++;
        req  = 4'h0;
        last = 4'h0;
        tick();
        total++;
        if (fp_valid !== 1'b0 || fp_grant !== 4'b0000 || fp_data_out !== 16'h1234) begin
            $display("FAIL fp_idle: valid=%b grant=%b data=%h required 0 0000 1234", fp_valid, fp_grant, fp_data_out);
        end else passed++;
    endtask

    task automatic test_burst_stall();
        logic [WIDTH-1:0] exp_d [4];
        logic             exp_v [4];
        exp_d = '{16'hA001, 16'hB002, 16'hB002, 16'hC003};
        exp_v = '{1'b1, 1'b1, 1'b0, 1'b1};
        req = 4'b0100;
        set_data(2, 16'hA001);
        tick();
        total++;
        if (fp_grant !== 4'b0100 || fp_valid !== 1'b0) begin
            $display("FAIL burst_grant: grant=%b valid=%b required 0100 0", fp_grant, fp_valid);
        end else passed++;
        for (int b = 0; b < 4; b++) begin
            case (b)
                0: begin req = 4'b0100; set_data(2, 16'hA001); end
                1: begin req = 4'b0100; set_data(2, 16'hB002); end
                2: begin req = 4'b0001; set_data(2, 16'h5555); end
                default: begin req = 4'b0101; last = 4'b0100; set_data(2, 16'hC003); end
            endcase
            tick();
            total++;
            if (fp_valid !== exp_v[b] || fp_data_out !== exp_d[b]) begin
                $display("FAIL burst_word%0d: valid=%b data=%h required %b %h",
                         b, fp_valid, fp_data_out, exp_v[b], exp_d[b]);
            end else passed++;
        end
        total++;
        if (fp_grant !== 4'b0000 || fp_busy !== 1'b0) begin
            $display("FAIL burst_release: grant=%b busy=%b required 0000 0", fp_grant, fp_busy);
        end else passed++;
        last = 4'h0;
        req  = 4'b0001;
        tick();
        total++;
        if (fp_grant !== 4'b0001 || fp_valid !== 1'b0) begin
            $display("FAIL burst_next_owner: grant=%b valid=%b required 0001 0", fp_grant, fp_valid);
        end else passed++;
        last = 4'b0001;
        tick();
        req  = 4'h0;
        last = 4'h0;
        tick();
    endtask

    task automatic test_contention();
        req = 4'b1000;
        set_data(3, 16'h3333);
        tick();
        total++;
        if (fp_grant !== 4'b1000) begin
            $display("FAIL cont_grant3: grant=%b required 1000", fp_grant);
        end else passed++;
        tick();
        req = 4'b1001;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (fp_grant !== 4'b1000 || fp_sel !== 2'd3 || fp_valid !== 1'b1) begin
                $display("FAIL cont_hold%0d: grant=%b sel=%0d valid=%b required 1000 3 1",
                         c, fp_grant, fp_sel, fp_valid);
            end else passed++;
        end
        last = 4'b1000;
        tick();
        total++;
        if (fp_grant !== 4'b0000 || fp_sel !== 2'd3 || fp_valid !== 1'b1) begin
            $display("FAIL cont_release: grant=%b sel=%0d valid=%b required 0000 3 1", fp_grant, fp_sel, fp_valid);
        end else passed++;
        last = 4'h0;
        req  = 4'b0001;
        tick();
        total++;
        if (fp_grant !== 4'b0001) begin
            $display("FAIL cont_grant0: grant=%b required 0001", fp_grant);
        end else passed++;
        last = 4'b0001;
        tick();
        req  = 4'h0;
        last = 4'h0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [N_CH-1:0] exp_rr [10];
        logic [N_CH-1:0] exp_fp [10];
        exp_rr = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        exp_fp = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001,
                   4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'hF;
        last  = 4'hF;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (rr_grant !== exp_rr[c]) begin
                $display("FAIL rr_grant cyc%0d: grant=%b required %b", c, rr_grant, exp_rr[c]);
            end else passed++;
            total++;
            if (fp_grant !== exp_fp[c]) begin
                $display("FAIL fp_regrant cyc%0d: grant=%b required %b", c, fp_grant, exp_fp[c]);
            end else passed++;
            if (c % 2 == 1) begin
                total++;
                if (rr_valid !== 1'b1 || rr_sel !== SEL_W'((c - 1) / 2)) begin
                    $display("FAIL rr_sel cyc%0d: valid=%b sel=%0d required 1 %0d",
                             c, rr_valid, rr_sel, (c - 1) / 2);
                end else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        // Round-robin pointer now rests at 1.
        req  = 4'b0010;
        last = 4'h0;
        set_data(1, 16'h0101);
        tick();
        total++;
        if (rr_grant !== 4'b0010) begin
            $display("FAIL mid_owner: grant=%b required 0010", rr_grant);
        end else passed++;
        tick();
        rst_n = 1'b0;
        tick();
        total++;
        if (rr_grant !== 4'b0000 || rr_valid !== 1'b0 || rr_busy !== 1'b0 || rr_data_out !== 16'h0000) begin
            $display("FAIL mid_reset_rr: grant=%b valid=%b busy=%b data=%h required 0000 0 0 0000",
                     rr_grant, rr_valid, rr_busy, rr_data_out);
        end else passed++;
        total++;
        if (fp_grant !== 4'b0000 || fp_valid !== 1'b0) begin
            $display("FAIL mid_reset_fp: grant=%b valid=%b required 0000 0", fp_grant, fp_valid);
        end else passed++;
        rst_n = 1'b1;
        req   = 4'b0110;
        tick();
        total++;
        if (rr_grant !== 4'b0010) begin
            $display("FAIL mid_rearb_ptr0: grant=%b required 0010", rr_grant);
        end else passed++;
        req = 4'h0;
        tick();
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        rst_n   = 1'b0;
        req     = '0;
        last    = '0;
        data_in = '0;
        test_reset();
        test_fixed_priority();
        test_burst_stall();
        test_contention();
        test_round_robin();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
